// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//
// Converts a raw PS/2 keyboard stream (scan code set 2) into the 11-bit
// ps2_key event word {toggle, pressed, extended, code[7:0]} used by the core
// top levels. Bit 10 inverts once per key event so consumers can detect new
// events by edge.
//
// Ports:
//   clk_sys     in   system clock (only clock)
//   reset_n     in   asynchronous active-low reset
//   ps2_clk_in  in   raw PS/2 clock, asynchronous to clk_sys
//   ps2_dat_in  in   raw PS/2 data, asynchronous to clk_sys
//   ps2_key     out  event word {toggle, pressed, extended, code}
//   key_stb     out  one-cycle pulse in the cycle ps2_key updates
//   frame_err   out  one-cycle pulse when a frame is aborted
//
// Handshake: there is no backpressure. key_stb and frame_err are single-cycle
// qualifiers; ps2_key is valid whenever key_stb is high and holds its value
// until the next key_stb. key_stb and frame_err are mutually exclusive.
//
// Configuration macro: PS2_KEY_PARITY_EN
//   defined   - odd parity over data+parity is checked; a mismatch turns the
//               stop-bit cycle into a frame_err instead of a valid byte.
//   undefined - the parity bit is received and ignored.
//
// State for checkers: rx_state_q (frame receiver), dec_state_q (prefix decoder).

module ps2_key_encoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronisers, clock filter, falling-edge detect
  // ---------------------------------------------------------------------------
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk, filt_d1;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock follows only after FILTER_LEN consecutive cycles of
  // disagreement; any return to agreement restarts the count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_d1  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d1 <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d1 & ~filt_clk;

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          byte_ok_d, byte_ok;
  logic          rx_err_d;
  logic          par_ok;

`ifdef PS2_KEY_PARITY_EN
  logic par_bit;
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    byte_ok_d  = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // A high sample while idle is line noise, not an error.
        if (fall && !dat_s2) rx_state_d = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (fall && (bit_cnt == 3'd7)) rx_state_d = RX_PARITY;
      end
      RX_PARITY: begin
        if (fall) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (fall) begin
          rx_state_d = RX_IDLE;
          if (dat_s2 && par_ok) byte_ok_d = 1'b1;
          else                  rx_err_d  = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A falling edge always restarts the timeout, so it wins over expiry.
    if ((rx_state_q != RX_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1))) begin
      rx_state_d = RX_IDLE;
      rx_err_d   = 1'b1;
      byte_ok_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      byte_ok    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_KEY_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      byte_ok    <= byte_ok_d;
      frame_err  <= rx_err_d;

      if ((rx_state_d == RX_IDLE) || fall) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (rx_state_q)
          RX_IDLE:  bit_cnt <= '0;
          RX_SHIFT: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef PS2_KEY_PARITY_EN
          RX_PARITY: par_bit <= dat_s2;
`endif
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder and output register
  // shreg is stable while byte_ok is high: it only shifts in RX_SHIFT.
  // ---------------------------------------------------------------------------
  dec_state_t dec_state_q, dec_state_d;
  logic       emit, ev_pressed, ev_ext;
  logic       is_discard;

  always_comb begin
    is_discard = (shreg == 8'hE1) || (shreg == 8'hAA) || (shreg == 8'hFA) ||
                 (shreg == 8'hEE) || (shreg == 8'hFE) || (shreg == 8'h00) ||
                 (shreg == 8'hFF);
  end

  always_comb begin
    dec_state_d = dec_state_q;
    emit        = 1'b0;
    ev_pressed  = 1'b0;
    ev_ext      = 1'b0;
    if (byte_ok) begin
      if (shreg == 8'hE0) begin
        dec_state_d = DEC_EXT;
      end else if (shreg == 8'hF0) begin
        // Only a pending E0 turns a break into an extended break.
        dec_state_d = (dec_state_q == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
      end else begin
        case (dec_state_q)
          DEC_BASE: begin
            if (!is_discard) begin
              emit       = 1'b1;
              ev_pressed = 1'b1;
            end
          end
          DEC_EXT: begin
            emit        = 1'b1;
            ev_pressed  = 1'b1;
            ev_ext      = 1'b1;
            dec_state_d = DEC_BASE;
          end
          DEC_BRK: begin
            emit        = 1'b1;
            dec_state_d = DEC_BASE;
          end
          DEC_EXT_BRK: begin
            emit        = 1'b1;
            ev_ext      = 1'b1;
            dec_state_d = DEC_BASE;
          end
          default: dec_state_d = DEC_BASE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dec_state_q <= DEC_BASE;
      ps2_key     <= '0;
      key_stb     <= 1'b0;
    end else begin
      dec_state_q <= dec_state_d;
      key_stb     <= emit;
      if (emit) ps2_key <= {~ps2_key[10], ev_pressed, ev_ext, shreg};
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder
//
// Directed bench for ps2_key_encoder. Stimulus tasks drive PS/2 frames and
// push the hand-computed event word ({toggle, pressed, ext, code}) or an error
// marker into exp_q; a monitor on the falling clk_sys edge pops and compares
// every key_stb / frame_err the DUT produces.
//
// The PS/2 clock is run far faster than a real keyboard (80 clk_sys cycles per
// bit) and the timeout is shortened so the run stays short.

module tb_ps2_key_encoder;

  localparam int FILT = 8;
  localparam int TMO  = 400;
  localparam int HALF = 40;
  localparam logic [11:0] ERR_MARK = 12'h800;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        frame_err;

  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        tog = 1'b0;

  ps2_key_encoder #(
    .FILTER_LEN (FILT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .ps2_key   (ps2_key),
    .key_stb   (key_stb),
    .frame_err (frame_err)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge, away from the DUT sampling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends bits[0..n-1]; data changes while the PS/2 clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic flip_par, input logic stop);
    logic par;
    par = (~^b) ^ flip_par;
    send_bits({stop, par, b, 1'b0}, 11);
    wait_cyc(100);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b0, 1'b1);
  endtask

  task automatic expect_key(input logic p, input logic e, input logic [7:0] code);
    tog = ~tog;
    exp_q.push_back({1'b0, tog, p, e, code});
  endtask

  task automatic expect_err();
    exp_q.push_back(ERR_MARK);
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_sys) begin
    logic [11:0] e;
    logic [11:0] got;
    if (reset_n) begin
      if (key_stb && frame_err) begin
        checks++;
        errors++;
        $display("FAIL stb_err_overlap ps2_key=%h", ps2_key);
      end else if (key_stb || frame_err) begin
        checks++;
        got = frame_err ? ERR_MARK : {1'b0, ps2_key};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h (800=frame_err) exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL event got=%h exp=%h (800=frame_err)", got, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    wait_cyc(5);
    check("rst_key", ps2_key, 11'h000);
    check("rst_stb", {10'd0, key_stb}, 11'h000);
    check("rst_err", {10'd0, frame_err}, 11'h000);
    reset_n = 1'b1;
    wait_cyc(20);

    // make 1C, then break 1C
    expect_key(1'b1, 1'b0, 8'h1C); send_byte(8'h1C);
    send_byte(8'hF0);
    expect_key(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);

    // extended make / break of 75
    send_byte(8'hE0);
    expect_key(1'b1, 1'b1, 8'h75); send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    expect_key(1'b0, 1'b1, 8'h75); send_byte(8'h75);

    // short clock glitch while idle must produce nothing, then 29
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(50);
    expect_key(1'b1, 1'b0, 8'h29); send_byte(8'h29);

    // start + 4 data bits, then silence -> timeout; then a clean 16
    expect_err();
    send_bits({6'b0, 4'b0110, 1'b0}, 5);
    wait_cyc(TMO + 200);
    expect_key(1'b1, 1'b0, 8'h16); send_byte(8'h16);

    // 1C with flipped parity bit
`ifdef PS2_KEY_PARITY_EN
    expect_err();
    send_raw(8'h1C, 1'b1, 1'b1);
    check("parity_key_hold", ps2_key, {tog, 1'b1, 1'b0, 8'h16});
`else
    expect_key(1'b1, 1'b0, 8'h1C);
    send_raw(8'h1C, 1'b1, 1'b1);
`endif

    // discarded byte, then BRK -> E0 redirect to extended make
    send_byte(8'hAA);
    send_byte(8'hF0);
    send_byte(8'hE0);
    expect_key(1'b1, 1'b1, 8'h74); send_byte(8'h74);

    // bad stop bit, then a clean 4B
    expect_err();
    send_raw(8'h33, 1'b0, 1'b0);
    expect_key(1'b1, 1'b0, 8'h4B); send_byte(8'h4B);

    // reset in the middle of a frame discards it silently
    send_bits({5'b0, 5'b10101, 1'b0}, 6);
    reset_n = 1'b0;
    wait_cyc(3);
    check("midrst_key", ps2_key, 11'h000);
    check("midrst_err", {10'd0, frame_err}, 11'h000);
    reset_n = 1'b1;
    tog = 1'b0;
    wait_cyc(20);
    expect_key(1'b1, 1'b0, 8'h1C); send_byte(8'h1C);
    check("final_key", ps2_key, {1'b1, 1'b1, 1'b0, 8'h1C});

    // every expected event must have been seen
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cyc(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
